stream_mux_arb: RTL and testbench
=================================

// Module: stream_mux_arb
// PURPOSE
// - N-to-1 stream multiplexer with a valid/ready handshake on every channel.
// - Successor to the combinational select muxes: replaces the external sel with an internal arbiter.
// - Holds the grant across multi-beat packets and registers the output.
// - Sits between several producer channels and one shared consumer, e.g. a TX path or memory write port.
// PARAMETERS
// - CH_NUM     4  number of input channels, >= 2
// - DAT_WIDTH  8  data bus width per channel
// - ARB_MODE   ARB_RR  arbitration mode (mux_pkg::arb_mode_e): ARB_RR round-robin, ARB_FIXED lowest index wins
// - SEL_WIDTH  $clog2(CH_NUM)  derived, not overridden
// PORTS
// - clk_i    in   1                    single clock, rising edge
// - rst_n_i  in   1                    asynchronous reset, active-low
// - vld_i    in   CH_NUM               per-channel beat valid
// - dat_i    in   [CH_NUM][DAT_WIDTH]  per-channel data (packed 2-D)
// - lst_i    in   CH_NUM               per-channel last beat of packet
// - rdy_o    out  CH_NUM               per-channel ready
// - vld_o    out  1                    output beat valid
// - dat_o    out  DAT_WIDTH            output data
// - lst_o    out  1                    output last
// - ch_o     out  SEL_WIDTH            source channel of current output beat
// - rdy_i    in   1                    consumer ready
// BEHAVIOUR
// - Reset (async assert, sync release)
//   - vld_o = 0, dat_o = 0, lst_o = 0, ch_o = 0
//   - lock = 0; last-grant pointer ptr = CH_NUM-1, so channel 0 has first priority.
//   - All in-flight state is discarded, including reset asserted mid-packet. No beat is replayed.
// - Transfer rules
//   - A transfer occurs on a channel when vld_i[k] & rdy_o[k].
//   - A transfer occurs on the output when vld_o & rdy_i.
// - Output register (single stage)
//   - It is free when !vld_o | rdy_i.
//   - rdy_o[k] = free & grant[k]. At most one rdy_o bit is high; rdy_o is combinational from rdy_i.
//   - Latency: an accepted input beat appears on the outputs on the next cycle. Throughput is 1 beat/cycle.
//   - While vld_o & !rdy_i, dat_o, lst_o and ch_o hold stable.
//   - vld_o deasserts only after an output transfer with no new input accepted in the same cycle.
// - Arbitration (combinational, in the arbiter)
//   - Unlocked
//     - ARB_RR: grant goes to the first vld_i bit searching ptr+1, ptr+2, ... with wrap-around modulo CH_NUM.
//     - ARB_FIXED: grant goes to the lowest valid index.
//     - No valid input: grant = 0.
//   - Locked: grant = ptr only, whatever the other vld_i bits are. Gaps (vld_i[ptr]=0) keep the lock.
// - Lock FSM (2 states: IDLE, PKT)
//   - IDLE -> PKT: an accepted beat with lst_i=0. ptr is set to that channel.
//   - PKT -> IDLE: an accepted beat with lst_i=1 on ptr.
//   - Single-beat packet (lst_i=1): stays IDLE; ptr updates in ARB_RR.
//   - ptr updates only on an accepted beat, never on a stall.
//   - A stalled output (rdy_i=0) freezes grant, ptr and FSM.
// - Simultaneous events
//   - Output drain and new accept in the same cycle: the register reloads, vld_o stays 1.
//   - Requests arriving in the cycle a packet ends are arbitrated next cycle from the updated ptr.
// - No X propagation: unselected dat_i is never sampled.
// STRUCTURE
// - mux_pkg (shared)
//   - typedef enum logic {ARB_RR, ARB_FIXED} arb_mode_e
//   - function clog2_min1(n), returns >= 1 so SEL_WIDTH is never 0.
// - Sub-module rr_arbiter #(CH_NUM, ARB_MODE)
//   - Inputs: req, lock, ptr. Outputs: one-hot grant and encoded grant index.
//   - Purely combinational: double-width request vector rotated by ptr+1.
// - Top level holds ptr, the FSM and the output register.
// TESTING
// - Reset defaults: rst_n_i=0 mid-stream with vld_o=1 -> all outputs 0 immediately; after release, vld_i=4'b1111 first grants ch 0.
// - Fair rotation: ARB_RR, vld_i=4'b1111 with single-beat packets, rdy_i=1 -> ch_o sequence 0,1,2,3,0 with one beat/cycle.
// - Packet lock: ch1 sends a 3-beat packet (A1,A2,A3 with lst on A3) while ch0 and ch2 are valid -> output A1,A2,A3 contiguous with ch_o=1, then ch2.
// - Backpressure: rdy_i=0 for 5 cycles with vld_o=1, dat_o=8'h5A -> dat_o, lst_o and ch_o stay stable; rdy_o=0 on all channels; no beat lost or duplicated.
// - Gap in locked packet: vld_i[2] drops for 3 cycles mid-packet while ch3 is valid -> no ch3 grant until ch2 delivers its lst beat.
// - Fixed mode: ARB_FIXED, ch0 valid every cycle with single beats -> ch3 is never granted; scoreboard checks order and data integrity per channel.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types and helpers for the stream multiplexer and its arbiter.
package mux_pkg;

  typedef enum logic {ARB_RR, ARB_FIXED} arb_mode_e;

  typedef enum logic {ST_IDLE, ST_PKT} lock_state_e;

  // Select width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: round-robin or fixed priority, with a lock that pins
// the grant to ptr for the duration of a packet.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int        CH_NUM    = 4,
  parameter arb_mode_e ARB_MODE  = ARB_RR,
  localparam int       SEL_WIDTH = clog2_min1(CH_NUM)
) (
  input  logic [CH_NUM-1:0]    req_i,
  input  logic                 lock_i,
  input  logic [SEL_WIDTH-1:0] ptr_i,
  output logic [CH_NUM-1:0]    gnt_o,
  output logic [SEL_WIDTH-1:0] gnt_idx_o
);

  logic [2*CH_NUM-1:0] dbl;
  logic [2*CH_NUM-1:0] rot;
  logic                found;
  int                  sel;

  always_comb begin
    found = 1'b0;
    sel   = 0;
    dbl   = {req_i, req_i};
    // Rotating the doubled vector puts channel ptr+1 at bit 0.
    rot   = dbl >> (int'(ptr_i) + 1);
    if (lock_i) begin
      found = 1'b1;
      sel   = int'(ptr_i);
    end else if (ARB_MODE == ARB_FIXED) begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (!found && req_i[i]) begin
          found = 1'b1;
          sel   = i;
        end
      end
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (!found && rot[i]) begin
          found = 1'b1;
          sel   = int'(ptr_i) + 1 + i;
          if (sel >= CH_NUM) sel = sel - CH_NUM;
        end
      end
    end
    gnt_o = '0;
    for (int k = 0; k < CH_NUM; k++) gnt_o[k] = found && (k == sel);
    gnt_idx_o = found ? SEL_WIDTH'(sel) : '0;
  end

endmodule

// File: rtl/stream_mux_arb.sv
// N-to-1 valid/ready stream mux with internal arbitration, packet lock and a
// single registered output stage.
module stream_mux_arb
  import mux_pkg::*;
#(
  parameter int        CH_NUM    = 4,
  parameter int        DAT_WIDTH = 8,
  parameter arb_mode_e ARB_MODE  = ARB_RR,
  localparam int       SEL_WIDTH = clog2_min1(CH_NUM)
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic [CH_NUM-1:0]                vld_i,
  input  logic [CH_NUM-1:0][DAT_WIDTH-1:0] dat_i,
  input  logic [CH_NUM-1:0]                lst_i,
  output logic [CH_NUM-1:0]                rdy_o,
  output logic                             vld_o,
  output logic [DAT_WIDTH-1:0]             dat_o,
  output logic                             lst_o,
  output logic [SEL_WIDTH-1:0]             ch_o,
  input  logic                             rdy_i
);

  logic                 vld_q, vld_d;
  logic [DAT_WIDTH-1:0] dat_q, dat_d;
  logic                 lst_q, lst_d;
  logic [SEL_WIDTH-1:0] ch_q, ch_d;
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
  lock_state_e          st_q, st_d;

  logic [CH_NUM-1:0]    gnt;
  logic [SEL_WIDTH-1:0] gnt_idx;
  logic                 free;
  logic                 acc;
  logic                 acc_lst;
  logic [DAT_WIDTH-1:0] dat_sel;

  rr_arbiter #(
    .CH_NUM   (CH_NUM),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .req_i     (vld_i),
    .lock_i    (st_q == ST_PKT),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign free    = !vld_q || rdy_i;
  assign rdy_o   = gnt & {CH_NUM{free}};
  assign acc     = |(vld_i & rdy_o);
  assign acc_lst = |(vld_i & rdy_o & lst_i);

  // AND-OR select so only the accepted channel's data reaches the register.
  always_comb begin
    dat_sel = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      if (vld_i[k] && rdy_o[k]) dat_sel = dat_sel | dat_i[k];
    end
  end

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    lst_d = lst_q;
    ch_d  = ch_q;
    ptr_d = ptr_q;
    st_d  = st_q;
    if (free) begin
      vld_d = acc;
      if (acc) begin
        dat_d = dat_sel;
        lst_d = acc_lst;
        ch_d  = gnt_idx;
      end
    end
    if (acc) begin
      case (st_q)
        ST_IDLE: begin
          if (!acc_lst) begin
            st_d  = ST_PKT;
            ptr_d = gnt_idx;
          end else if (ARB_MODE == ARB_RR) begin
            ptr_d = gnt_idx;
          end
        end
        ST_PKT: begin
          if (acc_lst) st_d = ST_IDLE;
        end
        default: st_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_q <= 1'b0;
      dat_q <= '0;
      lst_q <= 1'b0;
      ch_q  <= '0;
      ptr_q <= SEL_WIDTH'(CH_NUM - 1);
      st_q  <= ST_IDLE;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
      lst_q <= lst_d;
      ch_q  <= ch_d;
      ptr_q <= ptr_d;
      st_q  <= st_d;
    end
  end

  assign vld_o = vld_q;
  assign dat_o = dat_q;
  assign lst_o = lst_q;
  assign ch_o  = ch_q;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Scoreboard bench for stream_mux_arb: one round-robin and one fixed-priority
// instance, per-channel source queues, and a monitor that pops expected beats.
module tb_stream_mux_arb;
  import mux_pkg::*;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic [1:0] c;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0][3:0]      vld_a, lst_a;
  logic [1:0][3:0][7:0] dat_a;
  logic [1:0]           rdyi_a;

  logic [3:0] rdyo0, rdyo1;
  logic       vo0, vo1, lo0, lo1;
  logic [7:0] do0, do1;
  logic [1:0] co0, co1;

  stream_mux_arb #(.CH_NUM(4), .DAT_WIDTH(8), .ARB_MODE(ARB_RR)) u_rr (
    .clk_i(clk), .rst_n_i(rst_n), .vld_i(vld_a[0]), .dat_i(dat_a[0]), .lst_i(lst_a[0]),
    .rdy_o(rdyo0), .vld_o(vo0), .dat_o(do0), .lst_o(lo0), .ch_o(co0), .rdy_i(rdyi_a[0]));

  stream_mux_arb #(.CH_NUM(4), .DAT_WIDTH(8), .ARB_MODE(ARB_FIXED)) u_fx (
    .clk_i(clk), .rst_n_i(rst_n), .vld_i(vld_a[1]), .dat_i(dat_a[1]), .lst_i(lst_a[1]),
    .rdy_o(rdyo1), .vld_o(vo1), .dat_o(do1), .lst_o(lo1), .ch_o(co1), .rdy_i(rdyi_a[1]));

  beat_t      expq0[$];
  beat_t      expq1[$];
  logic [8:0] src[2][4][16];
  int         hd[2][4];
  int         tl[2][4];
  logic [1:0][3:0] gap;
  int         nvec = 0;
  int         nerr = 0;

  logic [1:0]      s_vo;
  logic [1:0][7:0] s_do;
  logic [1:0]      s_lo;
  logic [1:0][1:0] s_co;
  logic [1:0][3:0] s_ro;

  logic [1:0]  pstall;
  logic [11:0] pbeat[2];

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic mon(input int d, input logic v, input logic [7:0] dt, input logic l,
                     input logic [1:0] c, input logic [3:0] ro);
    beat_t e;
    chk("rdy_onehot", int'($onehot0(ro)), 1);
    if (pstall[d]) chk("stall_hold", int'({v, dt, l, c}), int'(pbeat[d]));
    if (v && rdyi_a[d]) begin
      if ((d == 0 && expq0.size() == 0) || (d == 1 && expq1.size() == 0)) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_beat dut%0d: got dat %0h ch %0d, required no beat", d, dt, c);
      end else begin
        if (d == 0) e = expq0.pop_front();
        else        e = expq1.pop_front();
        chk("out_dat", int'(dt), int'(e.d));
        chk("out_lst", int'(l), int'(e.l));
        chk("out_ch", int'(c), int'(e.c));
      end
    end
    pstall[d] = v && !rdyi_a[d];
    pbeat[d]  = {v, dt, l, c};
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, vo0, do0, lo0, co0, rdyo0);
      mon(1, vo1, do1, lo1, co1, rdyo1);
    end else begin
      pstall = '0;
    end
  end

  task automatic drive();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 4; c++) begin
        if (hd[d][c] < tl[d][c] && !gap[d][c]) begin
          {lst_a[d][c], dat_a[d][c]} = src[d][c][hd[d][c]];
          vld_a[d][c] = 1'b1;
        end else begin
          vld_a[d][c] = 1'b0;
          dat_a[d][c] = 8'h00;
          lst_a[d][c] = 1'b0;
        end
      end
    end
  endtask

  task automatic push(input int d, input int c, input int dat, input int lst);
    src[d][c][tl[d][c]] = {lst[0], dat[7:0]};
    tl[d][c]++;
  endtask

  task automatic expb(input int d, input int dat, input int lst, input int c);
    beat_t e;
    e.d = dat[7:0];
    e.l = lst[0];
    e.c = c[1:0];
    if (d == 0) expq0.push_back(e);
    else        expq1.push_back(e);
  endtask

  task automatic clear_all();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 4; c++) begin
        hd[d][c] = 0;
        tl[d][c] = 0;
      end
    end
    gap = '0;
    expq0.delete();
    expq1.delete();
    drive();
  endtask

  task automatic step();
    logic [1:0][3:0] acc;
    @(negedge clk);
    acc[0] = vld_a[0] & rdyo0;
    acc[1] = vld_a[1] & rdyo1;
    s_vo = {vo1, vo0};
    s_do = {do1, do0};
    s_lo = {lo1, lo0};
    s_co = {co1, co0};
    s_ro = {rdyo1, rdyo0};
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 4; c++)
        if (acc[d][c]) hd[d][c]++;
    drive();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((expq0.size() + expq1.size()) != 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain_done", expq0.size() + expq1.size(), 0);
    step();
  endtask

  task automatic chk_rst();
    chk("rst_vld_rr", int'(vo0), 0);
    chk("rst_dat_rr", int'(do0), 0);
    chk("rst_lst_rr", int'(lo0), 0);
    chk("rst_ch_rr", int'(co0), 0);
    chk("rst_vld_fx", int'(vo1), 0);
    chk("rst_dat_fx", int'(do1), 0);
    chk("rst_lst_fx", int'(lo1), 0);
    chk("rst_ch_fx", int'(co1), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b1;
    vld_a  = '0;
    dat_a  = '0;
    lst_a  = '0;
    rdyi_a = 2'b11;
    pstall = '0;
    clear_all();
    #1 rst_n = 1'b0;
    #1 chk_rst();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Fair rotation, single beats, one beat per cycle.
    for (int c = 0; c < 4; c++) begin
      push(0, c, 8'h10 + c, 1);
      push(0, c, 8'h20 + c, 1);
    end
    for (int c = 0; c < 4; c++) expb(0, 8'h10 + c, 1, c);
    for (int c = 0; c < 4; c++) expb(0, 8'h20 + c, 1, c);
    drive();
    step();
    chk("rr_first_gnt", int'(s_ro[0]), 4'b0001);
    repeat (8) begin
      step();
      chk("rr_thruput", int'(s_vo[0]), 1);
    end
    drain(40);

    // Reset asserted in the middle of a locked packet on ch1.
    push(0, 1, 8'h41, 0);
    push(0, 1, 8'h42, 0);
    push(0, 1, 8'h43, 1);
    expb(0, 8'h41, 0, 1);
    expb(0, 8'h42, 0, 1);
    expb(0, 8'h43, 1, 1);
    drive();
    step();
    step();
    chk("rst_pre_vld", int'(vo0), 1);
    rst_n = 1'b0;
    #1 chk_rst();
    clear_all();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      push(0, c, 8'h50 + c, 1);
      expb(0, 8'h50 + c, 1, c);
    end
    drive();
    step();
    chk("rst_mid_first_gnt", int'(s_ro[0]), 4'b0001);
    drain(40);

    // Packet lock: ch1 three-beat packet while ch0 and ch2 are valid.
    push(0, 0, 8'h60, 1);
    push(0, 0, 8'h61, 1);
    push(0, 1, 8'hA1, 0);
    push(0, 1, 8'hA2, 0);
    push(0, 1, 8'hA3, 1);
    push(0, 2, 8'h62, 1);
    expb(0, 8'h60, 1, 0);
    expb(0, 8'hA1, 0, 1);
    expb(0, 8'hA2, 0, 1);
    expb(0, 8'hA3, 1, 1);
    expb(0, 8'h62, 1, 2);
    expb(0, 8'h61, 1, 0);
    drive();
    drain(40);

    // Backpressure: hold 5A for five stalled cycles while ch1 waits.
    push(0, 3, 8'h5A, 1);
    expb(0, 8'h5A, 1, 3);
    drive();
    step();
    rdyi_a[0] = 1'b0;
    push(0, 1, 8'h7B, 1);
    expb(0, 8'h7B, 1, 1);
    drive();
    repeat (5) begin
      step();
      chk("stall_vld", int'(s_vo[0]), 1);
      chk("stall_dat", int'(s_do[0]), 8'h5A);
      chk("stall_lst", int'(s_lo[0]), 1);
      chk("stall_ch", int'(s_co[0]), 3);
      chk("stall_rdy", int'(s_ro[0]), 0);
    end
    rdyi_a[0] = 1'b1;
    drain(40);

    // Gap inside a locked ch2 packet while ch3 is waiting.
    push(0, 2, 8'hB1, 0);
    push(0, 2, 8'hB2, 0);
    push(0, 2, 8'hB3, 0);
    push(0, 2, 8'hB4, 1);
    push(0, 3, 8'hC1, 1);
    expb(0, 8'hB1, 0, 2);
    expb(0, 8'hB2, 0, 2);
    expb(0, 8'hB3, 0, 2);
    expb(0, 8'hB4, 1, 2);
    expb(0, 8'hC1, 1, 3);
    drive();
    step();
    step();
    gap[0][2] = 1'b1;
    drive();
    repeat (3) begin
      step();
      chk("gap_no_ch3", int'(s_ro[0][3]), 0);
    end
    gap[0][2] = 1'b0;
    drive();
    drain(40);

    // Fixed priority: ch0 busy every cycle starves ch3.
    for (int i = 0; i < 6; i++) begin
      push(1, 0, 8'h80 + i, 1);
      expb(1, 8'h80 + i, 1, 0);
    end
    push(1, 1, 8'h91, 1);
    push(1, 3, 8'hF0, 1);
    push(1, 3, 8'hF1, 1);
    expb(1, 8'h91, 1, 1);
    expb(1, 8'hF0, 1, 3);
    expb(1, 8'hF1, 1, 3);
    drive();
    repeat (6) begin
      step();
      chk("fix_no_ch3", int'(s_ro[1][3]), 0);
    end
    drain(40);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
